prim_filter_bank: RTL and testbench

Multi-channel debounce/glitch filter with per-channel enable, runtime-programmable stability threshold, and edge-event outputs. It is the parametrised successor to the fixed-depth single-bit filter. Each channel uses a saturating counter instead of a shift-register match, so the required stable time can be changed at runtime without rebuilding. It sits between pad/GPIO inputs and consumers such as GPIO interrupt logic, the pinmux wakeup detector and the debounce stage of a sysrst controller.

---
 rtl/prim_filter_pkg.sv | 12 +
 rtl/prim_filter_ctr_chan.sv | 57 +++++
 rtl/prim_filter_bank.sv | 62 ++++++
 tb/tb_prim_filter_bank.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/prim_filter_pkg.sv
// Shared types and default widths for the prim_filter_bank family.
package prim_filter_pkg;

    localparam int unsigned FiltDefaultWidth    = 8;
    localparam int unsigned FiltDefaultCntWidth = 16;

    typedef struct packed {
        logic rise;
        logic fall;
    } filt_evt_t;

endpackage

// File: rtl/prim_filter_ctr_chan.sv
// One debounce channel: saturating qualification counter, stored value and edge events.
module prim_filter_ctr_chan
    import prim_filter_pkg::*;
#(
    parameter int unsigned CntWidth = FiltDefaultCntWidth
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic [CntWidth-1:0] thresh_i,
    input  logic                in_i,
    output logic                filter_o,
    output logic                rise_o,
    output logic                fall_o,
    output logic                pending_o
);

    logic                stored_q, stored_d;
    logic [CntWidth-1:0] ctr_q, ctr_d;
    filt_evt_t           evt_q, evt_d;

    always_comb begin
        stored_d = stored_q;
        ctr_d    = '0;
        evt_d    = '{rise: 1'b0, fall: 1'b0};
        if (!enable_i) begin
            stored_d = in_i;
        end else if (in_i != stored_q) begin
            if (ctr_q >= thresh_i) begin
                stored_d   = in_i;
                evt_d.rise = in_i;
                evt_d.fall = ~in_i;
            end else begin
                // Cannot wrap: ctr_q < thresh_i <= max value.
                ctr_d = ctr_q + CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stored_q <= 1'b0;
            ctr_q    <= '0;
            evt_q    <= '{rise: 1'b0, fall: 1'b0};
        end else begin
            stored_q <= stored_d;
            ctr_q    <= ctr_d;
            evt_q    <= evt_d;
        end
    end

    assign filter_o  = enable_i ? stored_q : in_i;
    assign rise_o    = evt_q.rise;
    assign fall_o    = evt_q.fall;
    assign pending_o = (ctr_q != '0);

endmodule

// File: rtl/prim_filter_bank.sv
// Multi-channel debounce filter bank with runtime threshold and edge events.
// Optional 2-flop input synchroniser enabled by defining PRIM_FILTER_BANK_SYNC_EN.
module prim_filter_bank
    import prim_filter_pkg::*;
#(
    parameter int unsigned Width    = FiltDefaultWidth,
    parameter int unsigned CntWidth = FiltDefaultCntWidth
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [Width-1:0]    enable_i,
    input  logic [CntWidth-1:0] thresh_i,
    input  logic [Width-1:0]    filter_i,
    output logic [Width-1:0]    filter_o,
    output logic [Width-1:0]    rise_o,
    output logic [Width-1:0]    fall_o,
    output logic [Width-1:0]    pending_o
);

    logic [Width-1:0] in_w;

`ifdef PRIM_FILTER_BANK_SYNC_EN
    logic [Width-1:0] sync1_q, sync1_d;
    logic [Width-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = filter_i;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign in_w = sync2_q;
`else
    assign in_w = filter_i;
`endif

    for (genvar k = 0; k < Width; k++) begin : g_chan
        prim_filter_ctr_chan #(
            .CntWidth (CntWidth)
        ) u_chan (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .enable_i  (enable_i[k]),
            .thresh_i  (thresh_i),
            .in_i      (in_w[k]),
            .filter_o  (filter_o[k]),
            .rise_o    (rise_o[k]),
            .fall_o    (fall_o[k]),
            .pending_o (pending_o[k])
        );
    end

endmodule

// File: tb/tb_prim_filter_bank.sv
// Self-checking bench for prim_filter_bank (Width=4, CntWidth=4) against a run-length model.
module tb_prim_filter_bank;

    localparam int W  = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  enable = '1;
    logic [CW-1:0] thresh = 4'd3;
    logic [W-1:0]  filt = '0;
    logic [W-1:0]  filter_o, rise_o, fall_o, pending_o;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: per channel, the settled value and how many consecutive
    // edges the input has disagreed with it.
    bit m_stored [W];
    int m_run    [W];
    bit m_rise   [W];
    bit m_fall   [W];

    always #5 clk = ~clk;

    prim_filter_bank #(.Width(W), .CntWidth(CW)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .enable_i  (enable),
        .thresh_i  (thresh),
        .filter_i  (filt),
        .filter_o  (filter_o),
        .rise_o    (rise_o),
        .fall_o    (fall_o),
        .pending_o (pending_o)
    );

    task automatic model_reset();
        for (int k = 0; k < W; k++) begin
            m_stored[k] = 0; m_run[k] = 0; m_rise[k] = 0; m_fall[k] = 0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < W; k++) begin
            m_rise[k] = 0;
            m_fall[k] = 0;
            if (!enable[k]) begin
                m_stored[k] = filt[k];
                m_run[k]    = 0;
            end else if (filt[k] == m_stored[k]) begin
                m_run[k] = 0;
            end else if (m_run[k] >= int'(thresh)) begin
                m_stored[k] = filt[k];
                m_run[k]    = 0;
                m_rise[k]   = filt[k];
                m_fall[k]   = !filt[k];
            end else begin
                m_run[k]++;
            end
        end
    endtask

    task automatic check(input string tag);
        logic [W-1:0] e_f, e_r, e_fl, e_p;
        for (int k = 0; k < W; k++) begin
            e_f[k]  = enable[k] ? m_stored[k] : filt[k];
            e_r[k]  = m_rise[k];
            e_fl[k] = m_fall[k];
            e_p[k]  = (m_run[k] != 0);
        end
        n_cmp += 4;
        assert (filter_o === e_f) else begin
            n_err++; $error("FAIL %s filter_o got %b exp %b", tag, filter_o, e_f);
        end
        assert (rise_o === e_r) else begin
            n_err++; $error("FAIL %s rise_o got %b exp %b", tag, rise_o, e_r);
        end
        assert (fall_o === e_fl) else begin
            n_err++; $error("FAIL %s fall_o got %b exp %b", tag, fall_o, e_fl);
        end
        assert (pending_o === e_p) else begin
            n_err++; $error("FAIL %s pending_o got %b exp %b", tag, pending_o, e_p);
        end
    endtask

    task automatic step(input logic [W-1:0] en, input logic [CW-1:0] th,
                        input logic [W-1:0] fi, input string tag);
        @(negedge clk);
        enable = en;
        thresh = th;
        filt   = fi;
        @(posedge clk);
        model_edge();
        #1;
        check(tag);
    endtask

    initial begin
        model_reset();
        #1;
        check("reset_async");
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) step(4'hF, 4'd3, 4'h0, "idle");

        // ch0 rises and holds: commits after the 4th edge.
        for (int i = 0; i < 6; i++) begin
            step(4'hF, 4'd3, 4'h1, "ch0_rise");
            if (i == 3) begin
                n_cmp++;
                assert (filter_o[0] === 1'b1 && rise_o[0] === 1'b1) else begin
                    n_err++; $error("FAIL ch0_commit got f=%b r=%b exp f=1 r=1", filter_o[0], rise_o[0]);
                end
            end
        end

        // ch1 glitch of 3 edges is swallowed.
        for (int i = 0; i < 3; i++) step(4'hF, 4'd3, 4'h3, "ch1_glitch");
        for (int i = 0; i < 3; i++) step(4'hF, 4'd3, 4'h1, "ch1_back");

        // T=0, ch2 toggling every cycle.
        for (int i = 0; i < 8; i++) step(4'hF, 4'd0, {1'b0, i[0], 2'b01}, "ch2_toggle");
        step(4'hF, 4'd3, 4'h1, "ch2_settle");

        // ch3 disabled mid-count, then re-enabled on a steady input.
        step(4'hF, 4'd3, 4'h9, "ch3_cnt");
        step(4'hF, 4'd3, 4'h9, "ch3_cnt");
        step(4'h7, 4'd3, 4'h9, "ch3_bypass");
        step(4'h7, 4'd3, 4'h9, "ch3_bypass");
        for (int i = 0; i < 3; i++) step(4'hF, 4'd3, 4'h9, "ch3_reen");
        step(4'hF, 4'd3, 4'h1, "ch3_clear");
        for (int i = 0; i < 5; i++) step(4'hF, 4'd3, 4'h1, "ch3_clear");

        // ch0 1->0 and ch1 0->1 together.
        for (int i = 0; i < 5; i++) begin
            step(4'hF, 4'd3, 4'h2, "simul");
            if (i == 3) begin
                n_cmp++;
                assert (fall_o[0] === 1'b1 && rise_o[1] === 1'b1) else begin
                    n_err++; $error("FAIL simul_evt got fall0=%b rise1=%b exp 1 1", fall_o[0], rise_o[1]);
                end
            end
        end

        // Randomized phase with a mid-run asynchronous reset.
        begin
            logic [W-1:0]  en_r = '1;
            logic [CW-1:0] th_r = 4'd2;
            logic [W-1:0]  fi_r = '0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 99) < 3) th_r = CW'($urandom_range(0, 6));
                if ($urandom_range(0, 99) < 4) en_r[$urandom_range(0, W-1)] ^= 1'b1;
                for (int k = 0; k < W; k++)
                    if ($urandom_range(0, 99) < 15) fi_r[k] = ~fi_r[k];
                step(en_r, th_r, fi_r, "rand");
                if (i == 1500) begin
                    @(negedge clk);
                    #2 rst_n = 1'b0;
                    model_reset();
                    #1;
                    check("reset_mid");
                    @(negedge clk);
                    rst_n = 1'b1;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
